// File: rtl/pixel_sensor_controller_if.sv
// Control/data bundle between the frame sequencer and the pixel array model.
// PIXEL_SENSOR_CONTROLLER_EXPOSE_CFG_EN adds the expose_len input.
interface pixel_sensor_controller_if #(
    parameter int DATA_W = 8
);
    logic              start;
`ifdef PIXEL_SENSOR_CONTROLLER_EXPOSE_CFG_EN
    logic [15:0]       expose_len;
`endif
    logic              busy;
    logic              anaReset;
    logic              expose;
    logic              convert;
    logic              read1;
    logic              read2;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pix_col1;
    logic [DATA_W-1:0] pix_col2;
    logic [DATA_W-1:0] pix_out1;
    logic [DATA_W-1:0] pix_out2;
    logic              pix_row;
    logic              pix_valid;
    logic              frame_done;

`ifdef PIXEL_SENSOR_CONTROLLER_EXPOSE_CFG_EN
    modport master (
        output start, expose_len, pix_col1, pix_col2,
        input  busy, anaReset, expose, convert, read1, read2,
        input  data, pix_out1, pix_out2, pix_row, pix_valid,
        input  frame_done
    );
    modport slave (
        input  start, expose_len, pix_col1, pix_col2,
        output busy, anaReset, expose, convert, read1, read2,
        output data, pix_out1, pix_out2, pix_row, pix_valid,
        output frame_done
    );
`else
    modport master (
        output start, pix_col1, pix_col2,
        input  busy, anaReset, expose, convert, read1, read2,
        input  data, pix_out1, pix_out2, pix_row, pix_valid,
        input  frame_done
    );
    modport slave (
        input  start, pix_col1, pix_col2,
        output busy, anaReset, expose, convert, read1, read2,
        output data, pix_out1, pix_out2, pix_row, pix_valid,
        output frame_done
    );
`endif
endinterface

// File: rtl/pixel_sensor_controller.sv
// One-frame erase/expose/convert/readout sequencer for the 2x2 pixel array.
// PIXEL_SENSOR_CONTROLLER_EXPOSE_CFG_EN: runtime exposure length via expose_len.
module pixel_sensor_controller #(
    parameter int ERASE_CYCLES  = 5,
    parameter int EXPOSE_CYCLES = 255,
    parameter int DATA_W        = 8,
    parameter int READ_CYCLES   = 2
) (
    input logic                  clk,
    input logic                  reset,
    pixel_sensor_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ1,
        S_READ2,
        S_DONE
    } state_e;

    // Counter reloads hold (duration - 1); the state exits when it reads 0.
    localparam logic [31:0] ERASE_LD = 32'(ERASE_CYCLES - 1);
    localparam logic [31:0] CONV_LD  = 32'((2 ** DATA_W) - 1);
    localparam logic [31:0] READ_LD  = 32'(READ_CYCLES - 1);

    state_e            state_q;
    logic [31:0]       cnt_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic              erase_q;
    logic              expose_q;
    logic              convert_q;
    logic              read1_q;
    logic              read2_q;
    logic [DATA_W-1:0] out1_q;
    logic [DATA_W-1:0] out2_q;
    logic              row_q;
    logic              valid_q;
    logic              done_q;
    logic [31:0]       expose_ld_d;

`ifdef PIXEL_SENSOR_CONTROLLER_EXPOSE_CFG_EN
    logic [15:0] xlen_q;

    always_comb begin
        expose_ld_d = 32'd0;
        if (xlen_q != 16'd0)
            expose_ld_d = {16'd0, xlen_q} - 32'd1;
    end
`else
    always_comb expose_ld_d = 32'(EXPOSE_CYCLES - 1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            convert_q <= 1'b0;
            read1_q   <= 1'b0;
            read2_q   <= 1'b0;
            out1_q    <= '0;
            out2_q    <= '0;
            row_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_ERASE;
                        cnt_q   <= ERASE_LD;
                        busy_q  <= 1'b1;
                        erase_q <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (cnt_q == 32'd0) begin
                        state_q  <= S_EXPOSE;
                        cnt_q    <= expose_ld_d;
                        erase_q  <= 1'b0;
                        expose_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_EXPOSE: begin
                    if (cnt_q == 32'd0) begin
                        state_q   <= S_CONVERT;
                        cnt_q     <= CONV_LD;
                        expose_q  <= 1'b0;
                        convert_q <= 1'b1;
                        data_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_CONVERT: begin
                    if (cnt_q == 32'd0) begin
                        state_q   <= S_READ1;
                        cnt_q     <= READ_LD;
                        convert_q <= 1'b0;
                        read1_q   <= 1'b1;
                        data_q    <= '0;
                    end else begin
                        cnt_q  <= cnt_q - 32'd1;
                        data_q <= data_q + DATA_W'(1);
                    end
                end
                S_READ1: begin
                    if (cnt_q == 32'd0) begin
                        state_q <= S_READ2;
                        cnt_q   <= READ_LD;
                        read1_q <= 1'b0;
                        read2_q <= 1'b1;
                        out1_q  <= bus.pix_col1;
                        out2_q  <= bus.pix_col2;
                        row_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_READ2: begin
                    if (cnt_q == 32'd0) begin
                        state_q <= S_DONE;
                        read2_q <= 1'b0;
                        out1_q  <= bus.pix_col1;
                        out2_q  <= bus.pix_col2;
                        row_q   <= 1'b1;
                        valid_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PIXEL_SENSOR_CONTROLLER_EXPOSE_CFG_EN
    // Latched once per frame so mid-frame changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            xlen_q <= '0;
        else if (state_q == S_IDLE && bus.start)
            xlen_q <= bus.expose_len;
    end
`endif

    assign bus.busy       = busy_q;
    assign bus.anaReset   = erase_q;
    assign bus.expose     = expose_q;
    assign bus.convert    = convert_q;
    assign bus.read1      = read1_q;
    assign bus.read2      = read2_q;
    assign bus.data       = data_q;
    assign bus.pix_out1   = out1_q;
    assign bus.pix_out2   = out2_q;
    assign bus.pix_row    = row_q;
    assign bus.pix_valid  = valid_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_pixel_sensor_controller.sv
// Frame-timeline reference checks for pixel_sensor_controller.
// Build with PIXEL_SENSOR_CONTROLLER_EXPOSE_CFG_EN to cover expose_len.
module tb_pixel_sensor_controller;
    localparam int ERASE  = 5;
    localparam int EXPOSE = 255;
    localparam int DW     = 8;
    localparam int RC     = 2;
    localparam int CONV   = 1 << DW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pixel_sensor_controller_if #(.DATA_W(DW)) bus ();

    pixel_sensor_controller #(
        .ERASE_CYCLES (ERASE),
        .EXPOSE_CYCLES(EXPOSE),
        .DATA_W       (DW),
        .READ_CYCLES  (RC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_pix = '0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int xlen(input logic [15:0] len);
`ifdef PIXEL_SENSOR_CONTROLLER_EXPOSE_CFG_EN
        return (len == 16'd0) ? 1 : int'(len);
`else
        return (len == len) ? EXPOSE : EXPOSE;
`endif
    endfunction

    // {busy,anaReset,expose,convert,read1,read2,frame_done,pix_valid}
    function automatic logic [31:0] ctl_now();
        return 32'({bus.busy, bus.anaReset, bus.expose, bus.convert,
                    bus.read1, bus.read2, bus.frame_done, bus.pix_valid});
    endfunction

    function automatic logic [31:0] pix_now();
        return 32'({bus.pix_row, bus.pix_out1, bus.pix_out2});
    endfunction

    // Expected strobes in frame cycle n (1 = first erase cycle).
    function automatic logic [31:0] ctl_exp(input int n, input int x);
        int t1, t2, t3, t4, t5;
        t1 = ERASE + x;
        t2 = t1 + CONV;
        t3 = t2 + RC;
        t4 = t3 + RC;
        t5 = t4 + 1;
        return 32'({1'b1, n <= ERASE, n > ERASE && n <= t1,
                    n > t1 && n <= t2, n > t2 && n <= t3,
                    n > t3 && n <= t4, n == t5,
                    n == t3 + 1 || n == t5});
    endfunction

    function automatic logic [31:0] data_exp(input int n, input int x);
        int t1;
        t1 = ERASE + x;
        if (n > t1 && n <= t1 + CONV)
            return 32'(n - t1 - 1);
        return 32'd0;
    endfunction

    task automatic idle(input int k, input bit go,
                        input logic [15:0] len);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check("idle_ctl", ctl_now(), 32'd0);
            check("idle_data", 32'(bus.data), 32'd0);
            check("idle_pix", pix_now(), 32'(exp_pix));
            bus.start = go && (i == k - 1);
            bus.pix_col1 = 8'($urandom);
            bus.pix_col2 = 8'($urandom);
`ifdef PIXEL_SENSOR_CONTROLLER_EXPOSE_CFG_EN
            bus.expose_len = len;
`endif
        end
    endtask

    // pix = {row0 col1, row0 col2, row1 col1, row1 col2}
    task automatic frame(input int x, input bit hold,
                         input int abort_at, input logic [31:0] pix);
        int t3, t4, t5;
        t3 = ERASE + x + CONV + RC;
        t4 = t3 + RC;
        t5 = t4 + 1;
        for (int n = 1; n <= t5; n++) begin
            @(negedge clk);
            if (n == abort_at) begin
                #2 reset = 1'b1;
                #1;
                check("rst_ctl", ctl_now(), 32'd0);
                check("rst_data", 32'(bus.data), 32'd0);
                check("rst_pix", pix_now(), 32'd0);
                exp_pix = '0;
                bus.start = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            check("ctl", ctl_now(), ctl_exp(n, x));
            check("data", 32'(bus.data), data_exp(n, x));
            check("pix", pix_now(), 32'(exp_pix));
            if (n == t3) exp_pix = {1'b0, pix[31:16]};
            if (n == t4) exp_pix = {1'b1, pix[15:0]};
            bus.pix_col1 = (n == t3) ? pix[31:24] :
                           (n == t4) ? pix[15:8] : 8'($urandom);
            bus.pix_col2 = (n == t3) ? pix[23:16] :
                           (n == t4) ? pix[7:0] : 8'($urandom);
            bus.start = hold ? 1'b1 : 1'($urandom);
`ifdef PIXEL_SENSOR_CONTROLLER_EXPOSE_CFG_EN
            bus.expose_len = 16'($urandom_range(50, 200));
`endif
        end
    endtask

    initial begin
        logic [15:0] len;
        bus.start = 1'b0;
        bus.pix_col1 = '0;
        bus.pix_col2 = '0;
`ifdef PIXEL_SENSOR_CONTROLLER_EXPOSE_CFG_EN
        bus.expose_len = '0;
`endif
        repeat (2) @(negedge clk);
        check("reset_ctl", ctl_now(), 32'd0);
        check("reset_data", 32'(bus.data), 32'd0);
        check("reset_pix", pix_now(), 32'd0);
        reset = 1'b0;

        idle(2, 1'b1, 16'd10);
        frame(xlen(16'd10), 1'b0, 0, 32'h3CA511F0);
        idle(1, 1'b1, 16'd0);
        frame(xlen(16'd0), 1'b1, 0, $urandom);
        idle(1, 1'b1, 16'd7);
        frame(xlen(16'd7), 1'b1, 0, $urandom);

        for (int i = 0; i < 2; i++) begin
            len = 16'($urandom_range(0, 40));
            idle($urandom_range(1, 4), 1'b1, len);
            frame(xlen(len), 1'b0, 0, $urandom);
        end

        len = 16'($urandom_range(0, 40));
        idle(2, 1'b1, len);
        frame(xlen(len), 1'b0, ERASE + xlen(len) + 40, $urandom);
        len = 16'($urandom_range(0, 40));
        idle(3, 1'b1, len);
        frame(xlen(len), 1'b0, 0, $urandom);
        idle(3, 1'b0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
